jtag_debug_cmd_sync: RTL and testbench
======================================

Name: jtag_debug_cmd_sync

Overview:
- Next-generation system-clock side of the Nios II JTAG debug path, parametrised in IR width, shift-register width and queue depth.
- Sits between the virtual-JTAG TCK-domain logic, which provides `ir_in`, `sr`, `vs_udr` and `vs_uir`, and the CPU debug/OCI logic.
- Resynchronises update-DR and update-IR strobes into `clk` and snapshots the IR code and shift register on each update-DR.
- Decodes each snapshot into one-hot action / no-action strobes and queues the commands in a FIFO with a valid/ready handshake, so back-to-back JTAG updates are not lost while the CPU is busy.

Parameters:
- `IR_W`, 2: width of the virtual-JTAG IR code; `NCMD = 2**IR_W` command classes.
- `SR_W`, 38: width of the JTAG data shift register captured into `cmd_jdo`.
- `ACT_BIT`, 34: bit of `sr` that qualifies a command as action (1) or no-action (0); must be less than `SR_W`.
- `DEPTH`, 4: command FIFO depth; a power of 2, minimum 2.
- `SYNC_STAGES`, 3: flops per strobe synchroniser, minimum 2.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `ir_in`  in  `IR_W`  IR code from the TCK domain; quasi-static around update-DR.
- `sr`  in  `SR_W`  shift register from the TCK domain; quasi-static around update-DR.
- `vs_udr`  in  1  virtual update-DR strobe, asynchronous to `clk`.
- `vs_uir`  in  1  virtual update-IR strobe, asynchronous to `clk`.
- `cmd_ready`  in  1  consumer accepts the head command.
- `clear_overflow`  in  1  clears the sticky `overflow` flag.
- `cmd_valid`  out  1  FIFO holds at least one command.
- `cmd_ir`  out  `IR_W`  IR code of the head command.
- `cmd_jdo`  out  `SR_W`  `sr` snapshot of the head command.
- `cmd_action`  out  `NCMD`  one-hot `take_action` for the head command, qualified by `cmd_valid`.
- `cmd_no_action`  out  `NCMD`  one-hot `take_no_action` for the head command, qualified by `cmd_valid`.
- `ir_update`  out  1  one-cycle pulse per update-IR; not queued.
- `fifo_level`  out  `clog2(DEPTH)+1`  number of queued commands.
- `overflow`  out  1  sticky flag: a command was dropped.

Behaviour:
- Reset: all flops cleared asynchronously.
  - Outputs after reset: `cmd_valid`=0, `cmd_ir`=0, `cmd_jdo`=0, `cmd_action`=0, `cmd_no_action`=0, `ir_update`=0, `fifo_level`=0, `overflow`=0.
  - Reset mid-operation discards all queued commands and any in-flight strobe.
- Synchronisers:
  - `vs_udr` and `vs_uir` each pass through `SYNC_STAGES` flops, followed by one history flop for rising-edge detect.
  - Each detector is disarmed at reset and arms only after its synchronised strobe has been seen low at least once. A strobe held high across reset release produces no pulse.
- Capture:
  - An armed rising edge on synced `udr` produces `cap`, exactly `SYNC_STAGES`+1 `clk` edges after `vs_udr` rises.
  - In the `cap` cycle, `{ir_in, sr}` is sampled directly and pushed into the FIFO. Both are required stable by the TCK domain from update-DR until the next shift.
- `ir_update`: a single-cycle pulse with the same latency rule, driven from synced `uir`.
- FIFO:
  - Registered, show-ahead; the pointers are `clog2(DEPTH)+1` bits with wrap-around.
  - A push is visible on `cmd_valid` and the head outputs one cycle after `cap`.
  - A pop occurs when `cmd_valid` and `cmd_ready` are both high; the next entry appears on the following cycle.
  - `cmd_ready` while empty has no effect.
  - Push and pop in the same cycle: both take effect and `fifo_level` is unchanged. This includes the full case: a push while full with a simultaneous pop is accepted.
  - Push while full without a pop: the command is dropped and `overflow` is set. `fifo_level` stays at `DEPTH`.
  - `clear_overflow` clears `overflow` on the next edge. If a new drop occurs in the same cycle, set wins.
- Decode (combinational from the head entry):
  - `cmd_action[k]` = `cmd_valid` AND (`cmd_ir`==k) AND `cmd_jdo[ACT_BIT]`.
  - `cmd_no_action[k]` = `cmd_valid` AND (`cmd_ir`==k) AND NOT `cmd_jdo[ACT_BIT]`.
  - At most one bit across both vectors is high.
- Head outputs hold their value while `cmd_valid` is high and `cmd_ready` is low. When the FIFO is empty, `cmd_ir` and `cmd_jdo` hold their last value, but the decode vectors read 0.
- Synchronised `udr` and `uir` edges in the same cycle: both are processed independently.

Test Plan:
- Reset release with `vs_udr` held 1, then lowered and raised once → exactly one command; `fifo_level` goes 0→1.
- Default parameters: `ir_in`=2'b01, `sr[34]`=1, `sr`=38'h4_0000_00AB, pulse `vs_udr` with `cmd_ready`=0 → `cmd_valid` rises 5 clocks after the `vs_udr` edge; `cmd_action`=4'b0010, `cmd_no_action`=0, `cmd_jdo`=38'h4_0000_00AB.
- Same stimulus with `sr[34]`=0, `ir_in`=2'b11 → `cmd_no_action`=4'b1000, `cmd_action`=0.
- Six updates with `cmd_ready`=0 → `fifo_level`=4, `overflow`=1; the four oldest pop in order; `clear_overflow` → `overflow`=0.
- FIFO full, a push coincident with a pop (`cmd_ready`=1) → `fifo_level` stays 4, `overflow` stays 0, the new entry is popped last.
- Pulse `vs_uir` → a single `ir_update` pulse 4 clocks later; `fifo_level` unchanged.
- Assert `reset_n` with 3 commands queued → `cmd_valid`=0 and `fifo_level`=0 immediately.

Source files
------------

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock side of the JTAG debug command path.
// Resynchronises the virtual-JTAG update-DR / update-IR strobes, snapshots
// {ir_in, sr} on every update-DR and queues the snapshots in a small
// show-ahead FIFO. The head entry is decoded into one-hot action and
// no-action strobes for the CPU debug logic.
module jtag_debug_cmd_sync #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int ACT_BIT     = 34,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [SR_W-1:0]           sr,
  input  logic                      vs_udr,
  input  logic                      vs_uir,
  input  logic                      cmd_ready,
  input  logic                      clear_overflow,
  output logic                      cmd_valid,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [SR_W-1:0]           cmd_jdo,
  output logic [(2**IR_W)-1:0]      cmd_action,
  output logic [(2**IR_W)-1:0]      cmd_no_action,
  output logic                      ir_update,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow
);

  localparam int NCMD = 2**IR_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int EW   = IR_W + SR_W;
  localparam int LAST = SYNC_STAGES - 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_P   = (AW+1)'(1);

  // Synchroniser chains, fill tracker, history and arming flops
  logic [SYNC_STAGES-1:0] udr_sync_r;
  logic [SYNC_STAGES-1:0] uir_sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   udr_hist_r;
  logic                   uir_hist_r;
  logic                   udr_armed_r;
  logic                   uir_armed_r;
  logic                   udr_rise_s;
  logic                   uir_rise_s;
  logic                   cap_r;
  logic                   ir_update_r;

  // FIFO state
  logic [EW-1:0]          mem_r [DEPTH];
  logic [AW:0]            wr_r;
  logic [AW:0]            rd_r;
  logic [AW:0]            level_r;
  logic                   valid_r;
  logic [EW-1:0]          head_r;
  logic                   overflow_r;

  // FIFO next-state signals
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;
  logic                   full_s;
  logic [AW:0]            level_next_s;
  logic [AW:0]            rd_next_s;
  logic [AW:0]            wr_next_s;
  logic [AW:0]            remain_s;
  logic [EW-1:0]          head_next_s;

  // Strobe synchronisers; fill_r marks when the last stage holds a real sample,
  // so the all-zero reset contents of the chain can never arm a detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_r  <= '0;
      uir_sync_r  <= '0;
      fill_r      <= '0;
      udr_hist_r  <= 1'b0;
      uir_hist_r  <= 1'b0;
      udr_armed_r <= 1'b0;
      uir_armed_r <= 1'b0;
    end else begin
      udr_sync_r  <= {udr_sync_r[SYNC_STAGES-2:0], vs_udr};
      uir_sync_r  <= {uir_sync_r[SYNC_STAGES-2:0], vs_uir};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      udr_hist_r  <= udr_sync_r[LAST];
      uir_hist_r  <= uir_sync_r[LAST];
      udr_armed_r <= udr_armed_r | (fill_r[LAST] & ~udr_sync_r[LAST]);
      uir_armed_r <= uir_armed_r | (fill_r[LAST] & ~uir_sync_r[LAST]);
    end
  end

  // Armed rising-edge detection on the synchronised strobes
  always_comb begin
    udr_rise_s = udr_armed_r & udr_sync_r[LAST] & ~udr_hist_r;
    uir_rise_s = uir_armed_r & uir_sync_r[LAST] & ~uir_hist_r;
  end

  // Registered capture and update-IR pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r       <= 1'b0;
      ir_update_r <= 1'b0;
    end else begin
      cap_r       <= udr_rise_s;
      ir_update_r <= uir_rise_s;
    end
  end

  // FIFO control: push/pop/drop decisions, pointer and level updates
  always_comb begin
    pop_s  = valid_r & cmd_ready;
    full_s = (level_r == DEPTH_L);
    push_s = cap_r & (~full_s | pop_s);
    drop_s = cap_r & full_s & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + ONE_P;
      2'b01:   level_next_s = level_r - ONE_P;
      default: level_next_s = level_r;
    endcase
    rd_next_s = pop_s  ? (rd_r + ONE_P) : rd_r;
    wr_next_s = push_s ? (wr_r + ONE_P) : wr_r;
    remain_s  = pop_s  ? (level_r - ONE_P) : level_r;
  end

  // Next head entry: refill only when the head is consumed or the FIFO is empty,
  // otherwise the previous head (or last popped value) is held.
  always_comb begin
    head_next_s = head_r;
    if (pop_s || !valid_r) begin
      if (remain_s == '0) begin
        if (push_s) begin
          head_next_s = {ir_in, sr};
        end else begin
          head_next_s = head_r;
        end
      end else begin
        head_next_s = mem_r[rd_next_s[AW-1:0]];
      end
    end else begin
      head_next_s = head_r;
    end
  end

  // FIFO storage, pointers, head register and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_r       <= '0;
      rd_r       <= '0;
      level_r    <= '0;
      valid_r    <= 1'b0;
      head_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_r[AW-1:0]] <= {ir_in, sr};
      end
      wr_r    <= wr_next_s;
      rd_r    <= rd_next_s;
      level_r <= level_next_s;
      valid_r <= (level_next_s != '0);
      head_r  <= head_next_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_overflow) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Head decode into one-hot action / no-action strobes
  always_comb begin
    cmd_action    = '0;
    cmd_no_action = '0;
    for (int k = 0; k < NCMD; k++) begin
      cmd_action[k]    = valid_r & (head_r[EW-1:SR_W] == IR_W'(k)) &  head_r[ACT_BIT];
      cmd_no_action[k] = valid_r & (head_r[EW-1:SR_W] == IR_W'(k)) & ~head_r[ACT_BIT];
    end
  end

  assign cmd_valid  = valid_r;
  assign cmd_ir     = head_r[EW-1:SR_W];
  assign cmd_jdo    = head_r[SR_W-1:0];
  assign ir_update  = ir_update_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Self-checking bench for jtag_debug_cmd_sync: directed scenarios followed by
// randomized traffic, all checked every cycle against a queue-based model.
module tb_jtag_debug_cmd_sync;

  localparam int IR_W    = 2;
  localparam int SR_W    = 38;
  localparam int ACT_BIT = 34;
  localparam int DEPTH   = 4;
  localparam int EW      = IR_W + SR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [IR_W-1:0]   ir_in = '0;
  logic [SR_W-1:0]   sr = '0;
  logic              vs_udr = 1'b0;
  logic              vs_uir = 1'b0;
  logic              cmd_ready = 1'b0;
  logic              clear_overflow = 1'b0;
  logic              cmd_valid;
  logic [IR_W-1:0]   cmd_ir;
  logic [SR_W-1:0]   cmd_jdo;
  logic [3:0]        cmd_action;
  logic [3:0]        cmd_no_action;
  logic              ir_update;
  logic [2:0]        fifo_level;
  logic              overflow;

  always #5 clk = ~clk;

  jtag_debug_cmd_sync #(
    .IR_W(IR_W), .SR_W(SR_W), .ACT_BIT(ACT_BIT), .DEPTH(DEPTH), .SYNC_STAGES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
    .clear_overflow(clear_overflow), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir),
    .cmd_jdo(cmd_jdo), .cmd_action(cmd_action), .cmd_no_action(cmd_no_action),
    .ir_update(ir_update), .fifo_level(fifo_level), .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_head = '0;
  bit            exp_ovf = 1'b0;
  bit            exp_iru = 1'b0;
  int            udr_cd[$];
  int            uir_cd[$];
  bit            udr_armed = 1'b0;
  bit            uir_armed = 1'b0;
  bit            rnd_mode = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the model: strobe latencies, then queue semantics.
  task automatic model_edge();
    bit push, pop, was_full, drop;
    foreach (udr_cd[i]) udr_cd[i] = udr_cd[i] - 1;
    foreach (uir_cd[i]) uir_cd[i] = uir_cd[i] - 1;
    push = 1'b0;
    if (udr_cd.size() > 0 && udr_cd[0] == 0) begin
      void'(udr_cd.pop_front());
      push = 1'b1;
    end
    exp_iru = 1'b0;
    if (uir_cd.size() > 0 && uir_cd[0] == 0) begin
      void'(uir_cd.pop_front());
      exp_iru = 1'b1;
    end
    pop      = (exp_q.size() > 0) && cmd_ready;
    was_full = (exp_q.size() == DEPTH);
    drop     = push && was_full && !pop;
    if (pop) void'(exp_q.pop_front());
    if (push && !drop) exp_q.push_back({ir_in, sr});
    if (drop) exp_ovf = 1'b1;
    else if (clear_overflow) exp_ovf = 1'b0;
    if (exp_q.size() > 0) exp_head = exp_q[0];
  endtask

  task automatic compare();
    logic [3:0] ea, en;
    bit v;
    v  = (exp_q.size() > 0);
    ea = 4'b0000;
    en = 4'b0000;
    if (v) begin
      if (exp_head[ACT_BIT]) ea = 4'b0001 << exp_head[EW-1:SR_W];
      else                   en = 4'b0001 << exp_head[EW-1:SR_W];
    end
    check_val("cmd_valid", 64'(cmd_valid), 64'(v));
    check_val("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
    check_val("overflow", 64'(overflow), 64'(exp_ovf));
    check_val("ir_update", 64'(ir_update), 64'(exp_iru));
    check_val("cmd_ir", 64'(cmd_ir), 64'(exp_head[EW-1:SR_W]));
    check_val("cmd_jdo", 64'(cmd_jdo), 64'(exp_head[SR_W-1:0]));
    check_val("cmd_action", 64'(cmd_action), 64'(ea));
    check_val("cmd_no_action", 64'(cmd_no_action), 64'(en));
  endtask

  task automatic randomize_inputs();
    logic [63:0] r64;
    r64            = {$urandom(), $urandom()};
    sr             = r64[SR_W-1:0];
    ir_in          = 2'($urandom_range(0, 3));
    cmd_ready      = ($urandom_range(0, 2) == 0);
    clear_overflow = ($urandom_range(0, 7) == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    if (rnd_mode) randomize_inputs();
  endtask

  // Strobe pulse: high for two cycles, low for three.
  task automatic pulse(input bit u, input bit i);
    if (u) begin
      vs_udr = 1'b1;
      if (udr_armed) udr_cd.push_back(5);
    end
    if (i) begin
      vs_uir = 1'b1;
      if (uir_armed) uir_cd.push_back(4);
    end
    tick();
    tick();
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  // Called at a negedge: asserts reset, checks the async clear, releases.
  task automatic do_reset(input bit hold_udr);
    reset_n        = 1'b0;
    cmd_ready      = 1'b0;
    clear_overflow = 1'b0;
    vs_udr         = hold_udr;
    vs_uir         = 1'b0;
    #1;
    check_val("rst_valid", 64'(cmd_valid), 64'd0);
    check_val("rst_level", 64'(fifo_level), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    check_val("rst_iru", 64'(ir_update), 64'd0);
    check_val("rst_act", 64'({cmd_action, cmd_no_action}), 64'd0);
    check_val("rst_head", 64'({cmd_ir, cmd_jdo}), 64'd0);
    exp_q.delete();
    udr_cd.delete();
    uir_cd.delete();
    exp_ovf   = 1'b0;
    exp_iru   = 1'b0;
    exp_head  = '0;
    udr_armed = 1'b0;
    uir_armed = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    udr_armed = !hold_udr;
    uir_armed = 1'b1;
  endtask

  initial begin
    logic [SR_W-1:0] new_sr;
    logic [63:0]     r64;

    // Strobe held high across reset release: only the later clean edge counts
    do_reset(1'b1);
    vs_udr = 1'b0;
    repeat (3) tick();
    udr_armed = 1'b1;
    pulse(1'b1, 1'b0);
    check_val("held_high_level", 64'(fifo_level), 64'd1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    do_reset(1'b0);

    // Action command on IR 1
    ir_in = 2'b01;
    sr    = 38'h4_0000_00AB;
    pulse(1'b1, 1'b0);
    check_val("dir_act", 64'(cmd_action), 64'h2);
    check_val("dir_noact", 64'(cmd_no_action), 64'h0);
    check_val("dir_jdo", 64'(cmd_jdo), 64'h4_0000_00AB);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // No-action command on IR 3
    ir_in = 2'b11;
    sr    = 38'h0_1234_5678;
    pulse(1'b1, 1'b0);
    check_val("dir2_noact", 64'(cmd_no_action), 64'h8);
    check_val("dir2_act", 64'(cmd_action), 64'h0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    check_val("empty_hold_jdo", 64'(cmd_jdo), 64'h0_1234_5678);

    // Six updates without consumer: four kept, overflow flagged
    for (int n = 0; n < 6; n++) begin
      r64   = {$urandom(), $urandom()};
      sr    = r64[SR_W-1:0];
      ir_in = 2'($urandom_range(0, 3));
      pulse(1'b1, 1'b0);
    end
    check_val("ovf_level", 64'(fifo_level), 64'd4);
    check_val("ovf_flag", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    repeat (4) tick();
    cmd_ready      = 1'b0;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check_val("ovf_cleared", 64'(overflow), 64'd0);

    // Full FIFO with push coincident with pop
    for (int n = 0; n < 4; n++) begin
      r64   = {$urandom(), $urandom()};
      sr    = r64[SR_W-1:0];
      pulse(1'b1, 1'b0);
    end
    new_sr = 38'h2_5A5A_C3C3;
    sr     = new_sr;
    ir_in  = 2'b10;
    vs_udr = 1'b1;
    udr_cd.push_back(5);
    tick();
    tick();
    vs_udr = 1'b0;
    tick();
    tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check_val("full_pp_level", 64'(fifo_level), 64'd4);
    check_val("full_pp_ovf", 64'(overflow), 64'd0);
    cmd_ready = 1'b1;
    repeat (3) tick();
    cmd_ready = 1'b0;
    check_val("full_pp_last", 64'(cmd_jdo), 64'(new_sr));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // Update-IR pulse, then both strobes together
    pulse(1'b0, 1'b1);
    check_val("uir_level", 64'(fifo_level), 64'd0);
    pulse(1'b1, 1'b1);
    tick();

    // Reset with three commands queued and one update in flight
    cmd_ready = 1'b0;
    repeat (3) pulse(1'b1, 1'b0);
    vs_udr = 1'b1;
    udr_cd.push_back(5);
    tick();
    tick();
    do_reset(1'b0);

    // Randomized traffic
    rnd_mode = 1'b1;
    randomize_inputs();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       pulse(1'b1, 1'b0);
        1:       pulse(1'b0, 1'b1);
        2:       pulse(1'b1, 1'b1);
        default: repeat (2) tick();
      endcase
    end
    rnd_mode       = 1'b0;
    cmd_ready      = 1'b1;
    clear_overflow = 1'b0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
